// File: rtl/time_setter.sv
// time_setter
// Front-panel time-entry controller for the countdown time register.
// Four debounced button levels become field selection, BCD up/down with
// wrap, hold-to-repeat and a one-cycle commit strobe toward the register.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-low reset
//   btnMode      level, selects the next field while editing
//   btnUp        level, increments the selected field
//   btnDown      level, decrements the selected field
//   btnEnter     level, enters edit mode from IDLE or commits while editing
//   running      countdown active; blocks entry and aborts editing
//   setHour10 .. setSecond1  BCD digits presented to the time register
//   write        one-cycle load strobe (no back-pressure, no handshake)
//   editing      high in any EDIT state (registered)
//   field        00 none, 01 hour, 10 minute, 11 second (registered)
//   state_dbg    current FSM state encoding, for checkers
module time_setter #(
  parameter int unsigned MAX_HOUR      = 23,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnMode,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnEnter,
  input  logic       running,
  output logic [3:0] setHour10,
  output logic [3:0] setHour1,
  output logic [3:0] setMinute10,
  output logic [3:0] setMinute1,
  output logic [3:0] setSecond10,
  output logic [3:0] setSecond1,
  output logic       write,
  output logic       editing,
  output logic [1:0] field,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  localparam logic [7:0] HOUR_MAX = {4'(MAX_HOUR / 10), 4'(MAX_HOUR % 10)};
  localparam logic [7:0] MS_MAX   = 8'h59;

  state_t      state, state_nx;
  logic        edit_nx;
  logic [1:0]  field_nx;

  // Button bundles are ordered {enter, mode, up, down}.
  logic [3:0]  btn_s, btn_p, ev;
  logic        run_s, run_q;

  logic [7:0]  hour, minute, second;
  logic [31:0] hold_cnt;
  logic        armed, repeating;

  // Two-digit BCD helpers; tens and ones always move together.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)             return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)           return max;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Sync and edge detect. Both stages reset to 1 so a button held through
  // reset cannot produce an edge; the event itself is registered, giving the
  // two-edge latency from first sample to visible effect. running goes
  // through two stages so it lines up with a same-cycle Enter event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_s <= 4'hF;
      btn_p <= 4'hF;
      ev    <= 4'h0;
      run_s <= 1'b0;
      run_q <= 1'b0;
    end else begin
      btn_s <= {btnEnter, btnMode, btnUp, btnDown};
      btn_p <= btn_s;
      ev    <= btn_s & ~btn_p;
      run_s <= running;
      run_q <= run_s;
    end
  end

  // Priority Enter > Mode > Up/Down; simultaneous Up and Down cancel.
  logic ev_enter, ev_mode, ev_up, ev_dn;
  assign ev_enter = ev[3];
  assign ev_mode  = ev[2] & ~ev[3];
  assign ev_up    = ev[1] & ~ev[0] & ~ev[2] & ~ev[3];
  assign ev_dn    = ev[0] & ~ev[1] & ~ev[2] & ~ev[3];

  // btn_p holds the level aligned with the registered event.
  logic hold_up, hold_dn, in_edit, stay;
  assign hold_up = btn_p[1] & ~btn_p[0];
  assign hold_dn = btn_p[0] & ~btn_p[1];
  assign in_edit = (state == EDIT_H) || (state == EDIT_M) || (state == EDIT_S);
  assign stay    = in_edit && (state_nx == state);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ev_enter && !run_q) state_nx = EDIT_H;
      EDIT_H:  if (run_q) state_nx = IDLE;
               else if (ev_enter) state_nx = COMMIT;
               else if (ev_mode)  state_nx = EDIT_M;
      EDIT_M:  if (run_q) state_nx = IDLE;
               else if (ev_enter) state_nx = COMMIT;
               else if (ev_mode)  state_nx = EDIT_S;
      EDIT_S:  if (run_q) state_nx = IDLE;
               else if (ev_enter) state_nx = COMMIT;
               else if (ev_mode)  state_nx = EDIT_H;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    edit_nx  = 1'b0;
    field_nx = 2'b00;
    case (state_nx)
      EDIT_H:  begin edit_nx = 1'b1; field_nx = 2'b01; end
      EDIT_M:  begin edit_nx = 1'b1; field_nx = 2'b10; end
      EDIT_S:  begin edit_nx = 1'b1; field_nx = 2'b11; end
      default: begin edit_nx = 1'b0; field_nx = 2'b00; end
    endcase
  end

  // Auto-repeat: the press edge arms the counter; the first repeat comes
  // REPEAT_DELAY cycles after the edge, later ones every REPEAT_PERIOD.
  // Without arming, a button already held when editing starts never steps.
  logic start, keep, rpt_hit, step_up, step_dn;
  assign start   = stay && (ev_up || ev_dn);
  assign keep    = stay && armed && (hold_up || hold_dn);
  assign rpt_hit = keep && (repeating ? (hold_cnt == 32'(REPEAT_PERIOD))
                                      : (hold_cnt == 32'(REPEAT_DELAY)));
  assign step_up = stay && (ev_up || (!start && rpt_hit && hold_up));
  assign step_dn = stay && (ev_dn || (!start && rpt_hit && hold_dn));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      write   <= 1'b0;
      editing <= 1'b0;
      field   <= 2'b00;
    end else begin
      state   <= state_nx;
      write   <= (state_nx == COMMIT);
      editing <= edit_nx;
      field   <= field_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_cnt  <= 32'd0;
      armed     <= 1'b0;
      repeating <= 1'b0;
    end else if (start) begin
      hold_cnt  <= 32'd1;
      armed     <= 1'b1;
      repeating <= 1'b0;
    end else if (keep) begin
      if (rpt_hit) begin
        hold_cnt  <= 32'd1;
        repeating <= 1'b1;
      end else begin
        hold_cnt  <= hold_cnt + 32'd1;
      end
    end else begin
      hold_cnt  <= 32'd0;
      armed     <= 1'b0;
      repeating <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hour   <= 8'h00;
      minute <= 8'h00;
      second <= 8'h00;
    end else if (step_up) begin
      case (state)
        EDIT_H:  hour   <= bcd_inc(hour, HOUR_MAX);
        EDIT_M:  minute <= bcd_inc(minute, MS_MAX);
        EDIT_S:  second <= bcd_inc(second, MS_MAX);
        default: ;
      endcase
    end else if (step_dn) begin
      case (state)
        EDIT_H:  hour   <= bcd_dec(hour, HOUR_MAX);
        EDIT_M:  minute <= bcd_dec(minute, MS_MAX);
        EDIT_S:  second <= bcd_dec(second, MS_MAX);
        default: ;
      endcase
    end
  end

  assign {setHour10, setHour1}     = hour;
  assign {setMinute10, setMinute1} = minute;
  assign {setSecond10, setSecond1} = second;
  assign state_dbg                 = state;

endmodule

// File: tb/tb_time_setter.sv
module tb_time_setter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, btnMode, btnUp, btnDown, btnEnter, running;
  logic [3:0] setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1;
  logic       write, editing;
  logic [1:0] field;
  logic [2:0] state_dbg;

  time_setter #(.MAX_HOUR(23), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clock(clock), .reset(reset),
    .btnMode(btnMode), .btnUp(btnUp), .btnDown(btnDown), .btnEnter(btnEnter),
    .running(running),
    .setHour10(setHour10), .setHour1(setHour1),
    .setMinute10(setMinute10), .setMinute1(setMinute1),
    .setSecond10(setSecond10), .setSecond1(setSecond1),
    .write(write), .editing(editing), .field(field), .state_dbg(state_dbg)
  );

  localparam logic [3:0] B_ENT = 4'b1000, B_MODE = 4'b0100, B_UP = 4'b0010, B_DN = 4'b0001;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  // Every write pulse pushes the presented time; checks pop from exp_q order.
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          write_cnt = 0;

  always @(negedge clock) begin
    if (write) begin
      write_cnt <= write_cnt + 1;
      got_q.push_back({setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1});
    end
  end

  function automatic logic [23:0] cur_time();
    return {setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1};
  endfunction

  function automatic logic [7:0] bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [23:0] tm(input int h, input int m, input int s);
    return {bcd2(h), bcd2(m), bcd2(s)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] m);
    {btnEnter, btnMode, btnUp, btnDown} = m;
  endtask

  task automatic press(input logic [3:0] m);
    drive(m);
    tick(1);
    drive(4'b0000);
    tick(4);
  endtask

  task automatic drain_writes(input string name);
    logic [23:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: got no write expected %h", name, e);
      end else begin
        g = got_q.pop_front();
        check(name, 32'(g), 32'(e));
      end
    end
    check({name, "_extra"}, 32'(got_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  btns;
    logic [23:0] t;
    logic [1:0]  f;
    logic        ed;
    int          w;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] b, input logic [23:0] t,
                              input logic [1:0] f, input logic ed, input int w);
    vec_t v;
    v.btns = b; v.t = t; v.f = f; v.ed = ed; v.w = w;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_w;
    reset = 1'b0; running = 1'b0;
    drive(4'b0000);

    // Reset with Up and Enter held straight through release.
    btnUp = 1'b1; btnEnter = 1'b1;
    tick(3);
    check("rst_time",    32'(cur_time()), 32'd0);
    check("rst_write",   32'(write),      32'd0);
    check("rst_editing", 32'(editing),    32'd0);
    check("rst_field",   32'(field),      32'd0);
    check("rst_state",   32'(state_dbg),  32'd0);
    reset = 1'b1;
    tick(6);
    check("held_time",    32'(cur_time()), 32'd0);
    check("held_editing", 32'(editing),    32'd0);
    check("held_writes",  32'(write_cnt),  32'd0);
    drive(4'b0000);
    tick(3);

    // Main entry sequence then wrap/carry boundaries.
    add(B_ENT, tm(0,0,0), 2'b01, 1'b1, 0);
    for (int i = 1; i <= 3; i++) add(B_UP, tm(i,0,0), 2'b01, 1'b1, 0);
    add(B_MODE, tm(3,0,0),  2'b10, 1'b1, 0);
    add(B_DN,   tm(3,59,0), 2'b10, 1'b1, 0);
    add(B_MODE, tm(3,59,0), 2'b11, 1'b1, 0);
    for (int i = 1; i <= 10; i++) add(B_UP, tm(3,59,i), 2'b11, 1'b1, 0);
    add(B_ENT, tm(3,59,10), 2'b00, 1'b0, 1);
    add(B_ENT, tm(3,59,10), 2'b01, 1'b1, 1);
    for (int i = 2; i >= 0; i--) add(B_DN, tm(i,59,10), 2'b01, 1'b1, 1);
    add(B_DN,   tm(23,59,10), 2'b01, 1'b1, 1);
    add(B_UP,   tm(0,59,10),  2'b01, 1'b1, 1);
    add(B_DN,   tm(23,59,10), 2'b01, 1'b1, 1);
    add(B_MODE, tm(23,59,10), 2'b10, 1'b1, 1);
    add(B_UP,   tm(23,0,10),  2'b10, 1'b1, 1);
    add(B_DN,   tm(23,59,10), 2'b10, 1'b1, 1);
    add(B_UP,   tm(23,0,10),  2'b10, 1'b1, 1);
    for (int i = 1; i <= 10; i++) add(B_UP, tm(23,i,10), 2'b10, 1'b1, 1);
    add(B_DN,        tm(23,9,10), 2'b10, 1'b1, 1);
    add(B_UP | B_DN, tm(23,9,10), 2'b10, 1'b1, 1);
    add(B_ENT | B_UP, tm(23,9,10), 2'b00, 1'b0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      base_w = write_cnt;
      press(vecs[i].btns);
      if (write_cnt != base_w) exp_q.push_back(vecs[i].t);
      check($sformatf("vec%0d_time", i),    32'(cur_time()),    32'(vecs[i].t));
      check($sformatf("vec%0d_field", i),   32'(field),         32'(vecs[i].f));
      check($sformatf("vec%0d_editing", i), 32'(editing),       32'(vecs[i].ed));
      check($sformatf("vec%0d_writes", i),  32'(write_cnt),     32'(vecs[i].w));
    end
    drain_writes("table_write_val");

    // Exact write strobe timing.
    press(B_ENT);
    btnEnter = 1'b1;
    tick(1);
    btnEnter = 1'b0;
    check("wt_n0_write", 32'(write), 32'd0);
    tick(1);
    check("wt_n1_write", 32'(write),     32'd0);
    check("wt_n1_state", 32'(state_dbg), 32'd1);
    tick(1);
    check("wt_n2_write",   32'(write),     32'd1);
    check("wt_n2_state",   32'(state_dbg), 32'd4);
    check("wt_n2_editing", 32'(editing),   32'd0);
    check("wt_n2_field",   32'(field),     32'd0);
    tick(1);
    check("wt_n3_write", 32'(write),     32'd0);
    check("wt_n3_state", 32'(state_dbg), 32'd0);
    check("wt_count",    32'(write_cnt), 32'd3);
    exp_q.push_back(tm(23,9,10));
    drain_writes("wt_write_val");

    // Auto-repeat on seconds: steps at event cycles 0, 4, 6, 8.
    press(B_ENT); press(B_MODE); press(B_MODE);
    check("rp_field", 32'(field), 32'd3);
    btnUp = 1'b1;
    tick(1);
    for (int j = 1; j <= 14; j++) begin
      int steps;
      if (j == 10) btnUp = 1'b0;
      tick(1);
      steps = int'(j >= 2) + int'(j >= 6) + int'(j >= 8) + int'(j >= 10);
      check($sformatf("rp_edge%0d", j), 32'(cur_time()), 32'(tm(23,9,10 + steps)));
    end
    press(B_UP);
    check("rp_single", 32'(cur_time()), 32'(tm(23,9,15)));
    tick(10);
    check("rp_cleared", 32'(cur_time()), 32'(tm(23,9,15)));
    press(B_DN);
    check("rp_down", 32'(cur_time()), 32'(tm(23,9,14)));

    // running aborts editing and blocks entry.
    press(B_MODE); press(B_MODE);
    check("run_field_m", 32'(field), 32'd2);
    running = 1'b1;
    tick(4);
    check("run_editing", 32'(editing),    32'd0);
    check("run_field",   32'(field),      32'd0);
    check("run_state",   32'(state_dbg),  32'd0);
    check("run_time",    32'(cur_time()), 32'(tm(23,9,14)));
    check("run_writes",  32'(write_cnt),  32'd3);
    press(B_ENT);
    check("run_enter_blocked", 32'(editing), 32'd0);
    running = 1'b0;
    tick(3);

    // running and Enter sampled on the same edge while editing: no write.
    press(B_ENT);
    check("race_editing_in", 32'(editing), 32'd1);
    running = 1'b1; btnEnter = 1'b1;
    tick(1);
    btnEnter = 1'b0;
    tick(5);
    check("race_writes",  32'(write_cnt), 32'd3);
    check("race_editing", 32'(editing),   32'd0);
    running = 1'b0;
    tick(3);

    // Reset landing on the COMMIT edge cancels the strobe.
    press(B_ENT);
    btnEnter = 1'b1;
    tick(1);
    btnEnter = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("rc_write", 32'(write),      32'd0);
    check("rc_state", 32'(state_dbg),  32'd0);
    check("rc_time",  32'(cur_time()), 32'd0);
    reset = 1'b1;
    tick(3);
    check("rc_writes", 32'(write_cnt), 32'd3);
    drain_writes("final_write_val");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
